// File: rtl/clock_tick_sched.sv
// clock_tick_sched: 1 Hz tick prescaler, carry/enable sequencer and set-time
// mode FSM for an external seconds/minutes/hours counter chain.
//
// Parameters
//   TICK_DIV  clk cycles per second tick (>=2)
//   DEB_CYC   consecutive stable synced samples to accept a button edge (>=2)
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   btn_mode, btn_inc     raw bouncy push buttons
//   sec_z, min_z, hr_z    terminal-count flags from the counters
//   sec_en, min_en, hr_en counter enables
//   sec_clr               synchronous clear request to the seconds counter
//   tick                  one-cycle 1 Hz pulse
//   mode                  0=RUN, 1=SET_MIN, 2=SET_HR
module clock_tick_sched #(
    parameter int TICK_DIV = 50,
    parameter int DEB_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_z,
    input  logic       min_z,
    input  logic       hr_z,
    output logic       sec_en,
    output logic       min_en,
    output logic       hr_en,
    output logic       sec_clr,
    output logic       tick,
    output logic [1:0] mode
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_CYC);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC - 1);

    typedef enum logic [1:0] {RUN = 2'd0, SET_MIN = 2'd1, SET_HR = 2'd2, BAD = 2'd3} mode_t;

    mode_t         state, state_nxt;
    logic [PW-1:0] pre_cnt, pre_nxt;
    logic [1:0]    raw, press;
    logic          mode_press, inc_press;
    logic          unused_hr_z;

    // The hours terminal count has no carry destination.
    assign unused_hr_z = hr_z;
    assign raw = {btn_inc, btn_mode};
    assign mode_press = press[0];
    assign inc_press = press[1];

    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_btn
            logic          s1, s2, lvl, lvl_q;
            logic [DW-1:0] cnt;
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    s1 <= 1'b0;
                    s2 <= 1'b0;
                    lvl <= 1'b0;
                    lvl_q <= 1'b0;
                    cnt <= '0;
                end else begin
                    s1 <= raw[b];
                    s2 <= s1;
                    lvl_q <= lvl;
                    // lvl only follows s2 after DEB_CYC consecutive differing samples
                    if (s2 == lvl)
                        cnt <= '0;
                    else if (cnt == DEB_MAX) begin
                        lvl <= ~lvl;
                        cnt <= '0;
                    end else
                        cnt <= cnt + 1'b1;
                end
            assign press[b] = lvl & ~lvl_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= RUN;
            pre_cnt <= '0;
        end else begin
            state <= state_nxt;
            pre_cnt <= pre_nxt;
        end

    always_comb begin
        state_nxt = (state == BAD) ? RUN :
                    !mode_press    ? state :
                    (state == RUN) ? SET_MIN :
                    (state == SET_MIN) ? SET_HR : RUN;
        pre_nxt = (state != RUN) ? '0 : (pre_cnt == PRE_MAX) ? '0 : pre_cnt + 1'b1;
        tick = (state == RUN) && (pre_cnt == PRE_MAX);
        sec_en = tick;
        // a mode press in the same cycle swallows the increment
        min_en = (state == RUN) ? tick & sec_z : (state == SET_MIN) & inc_press & ~mode_press;
        hr_en = (state == RUN) ? tick & sec_z & min_z : (state == SET_HR) & inc_press & ~mode_press;
        sec_clr = (state == SET_HR) & mode_press;
        mode = state;
    end
endmodule

// File: tb/tb_clock_tick_sched.sv
// tb_clock_tick_sched: randomized self-checking bench against a behavioural model.
module tb_clock_tick_sched;
    localparam int TD = 5;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst, btn_mode, btn_inc, sec_z, min_z, hr_z;
    logic sec_en, min_en, hr_en, sec_clr, tick;
    logic [1:0] mode;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_tick_sched #(.TICK_DIV(TD), .DEB_CYC(DC)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_z(sec_z), .min_z(min_z), .hr_z(hr_z),
        .sec_en(sec_en), .min_en(min_en), .hr_en(hr_en),
        .sec_clr(sec_clr), .tick(tick), .mode(mode)
    );

    // Reference model: raw button seen two edges late, accepted level flips
    // after DEB_CYC consecutive samples disagreeing with it; phase counts
    // clock cycles spent in RUN modulo TICK_DIV.
    int         ph;
    logic [1:0] md;
    bit         p1[2], p2[2], acc[2], pr[2];
    int         run[2];

    function automatic int nrun(bit s, bit a, int r);
        return (s != a) ? r + 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 0;
            md <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                p1[i] <= 1'b0; p2[i] <= 1'b0; acc[i] <= 1'b0; pr[i] <= 1'b0; run[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                p1[i] <= (i == 0) ? btn_mode : btn_inc;
                p2[i] <= p1[i];
                if (nrun(p2[i], acc[i], run[i]) == DC) begin
                    acc[i] <= !acc[i];
                    run[i] <= 0;
                    pr[i] <= !acc[i];
                end else begin
                    run[i] <= nrun(p2[i], acc[i], run[i]);
                    pr[i] <= 1'b0;
                end
            end
            if (pr[0]) md <= (md == 2'd2) ? 2'd0 : md + 2'd1;
            ph <= (md == 2'd0) ? (ph + 1) % TD : 0;
        end
    end

    logic e_tick, e_min, e_hr, e_clr;
    logic [6:0] obs, expv;
    assign e_tick = (md == 2'd0) && (ph == TD - 1);
    assign e_min = (md == 2'd0) ? (e_tick && sec_z) : (md == 2'd1 && pr[1] && !pr[0]);
    assign e_hr = (md == 2'd0) ? (e_tick && sec_z && min_z) : (md == 2'd2 && pr[1] && !pr[0]);
    assign e_clr = (md == 2'd2) && pr[0];
    assign obs = {tick, sec_en, min_en, hr_en, sec_clr, mode};
    assign expv = {e_tick, e_tick, e_min, e_hr, e_clr, md};

    task automatic drv(input logic m, input logic i, input logic sz, input logic mz);
        @(negedge clk);
        btn_mode = m;
        btn_inc = i;
        sec_z = sz;
        min_z = mz;
        hr_z = 1'($urandom);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drv(1'($urandom), 1'($urandom), 1'b1, 1'b1);
            checks++;
            if (obs !== 7'd0) begin errors++; $display("FAIL reset obs=%b exp=%b", obs, 7'd0); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_run;
        int nt = 0;
        for (int k = 0; k < 30; k++) begin
            drv(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL run k=%0d obs=%b exp=%b", k, obs, expv); end
            if (tick) nt++;
        end
        checks++;
        if (nt !== 6) begin errors++; $display("FAIL run_tick_count got=%0d exp=6", nt); end
    endtask

    task automatic test_carries;
        for (int k = 0; k < 40; k++) begin
            drv(1'b0, 1'b0, (k < 20) ? 1'($urandom) : 1'b1, (k < 20) ? 1'($urandom) : 1'b1);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL carry k=%0d obs=%b exp=%b", k, obs, expv); end
        end
    endtask

    task automatic test_debounce;
        int lat = -1;
        for (int k = 0; k < 14; k++) begin
            drv(k < 2, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL glitch k=%0d obs=%b exp=%b", k, obs, expv); end
        end
        checks++;
        if (mode !== 2'd0) begin errors++; $display("FAIL glitch_mode got=%0d exp=0", mode); end
        for (int k = 0; k < 30; k++) begin
            drv(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL hold k=%0d obs=%b exp=%b", k, obs, expv); end
            if (lat < 0 && mode == 2'd1) lat = k;
        end
        checks++;
        if (lat !== DC + 3) begin errors++; $display("FAIL press_latency got=%0d exp=%0d", lat, DC + 3); end
        for (int k = 0; k < 12; k++) begin
            drv(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL release k=%0d obs=%b exp=%b", k, obs, expv); end
        end
        checks++;
        if (mode !== 2'd1) begin errors++; $display("FAIL held_once got=%0d exp=1", mode); end
    endtask

    task automatic test_set_min;
        int np = 0;
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 16; k++) begin
                drv(1'b0, k < 8, 1'($urandom), 1'b1);
                checks++;
                if (obs !== expv) begin errors++; $display("FAIL set_min p=%0d k=%0d obs=%b exp=%b", p, k, obs, expv); end
                if (min_en) np++;
            end
        checks++;
        if (np !== 3) begin errors++; $display("FAIL set_min_pulses got=%0d exp=3", np); end
    endtask

    task automatic test_set_hr_exit;
        int ic = -1;
        int it = -1;
        for (int k = 0; k < 16; k++) begin
            drv(k < 8, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL to_hr k=%0d obs=%b exp=%b", k, obs, expv); end
        end
        checks++;
        if (mode !== 2'd2) begin errors++; $display("FAIL to_hr_mode got=%0d exp=2", mode); end
        for (int k = 0; k < 40; k++) begin
            drv(k < 12, 1'b0, 1'($urandom), 1'($urandom));
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL exit k=%0d obs=%b exp=%b", k, obs, expv); end
            if (sec_clr && ic < 0) ic = k;
            if (tick && ic >= 0 && it < 0) it = k;
        end
        checks++;
        if (ic < 0 || it - ic !== TD) begin errors++; $display("FAIL first_tick clr=%0d tick=%0d exp_gap=%0d", ic, it, TD); end
        checks++;
        if (mode !== 2'd0) begin errors++; $display("FAIL exit_mode got=%0d exp=0", mode); end
    endtask

    task automatic test_simul;
        int nm = 0;
        for (int k = 0; k < 16; k++) begin
            drv(k < 8, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL to_min k=%0d obs=%b exp=%b", k, obs, expv); end
        end
        for (int k = 0; k < 16; k++) begin
            drv(k < 8, k < 8, 1'b0, 1'b1);
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL both k=%0d obs=%b exp=%b", k, obs, expv); end
            if (min_en) nm++;
        end
        checks++;
        if (nm !== 0 || mode !== 2'd2) begin errors++; $display("FAIL both_result min_en=%0d mode=%0d exp 0/2", nm, mode); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 7'd0) begin errors++; $display("FAIL async_rst obs=%b exp=%b", obs, 7'd0); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random;
        logic bm = 1'b0;
        logic bi = 1'b0;
        int lm = 0;
        int li = 0;
        for (int k = 0; k < 800; k++) begin
            if (lm == 0) begin bm = ~bm; lm = $urandom_range(1, 14); end
            if (li == 0) begin bi = ~bi; li = $urandom_range(1, 14); end
            lm--;
            li--;
            drv(bm, bi, 1'($urandom), 1'($urandom));
            checks++;
            if (obs !== expv) begin errors++; $display("FAIL random k=%0d obs=%b exp=%b", k, obs, expv); end
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        sec_z = 1'b0;
        min_z = 1'b0;
        hr_z = 1'b0;
        test_reset;
        test_run;
        test_carries;
        test_debounce;
        test_set_min;
        test_set_hr_exit;
        test_simul;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
